// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef enum logic {
    RUN     = 1'b0,
    MULWAIT = 1'b1
  } hz_state_e;

  // True when the ID instruction really reads rs and rs matches the EX destination.
  function automatic logic src_match(input logic uses, input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Stage fields in, stall/flush controls and performance counters out.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) ();

  logic [REG_W-1:0] rs1_D;
  logic [REG_W-1:0] rs2_D;
  logic             usesRs1_D;
  logic             usesRs2_D;
  logic [REG_W-1:0] rd_E;
  logic             memRead_E;
  logic             isMul_E;
  logic             branchTaken_M;

  logic             stall_F;
  logic             stall_D;
  logic             stall_E;
  logic             flush_D;
  logic             flush_E;
  logic             flush_M;
  logic             mulBusy;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushEvents;

  modport master (
    output rs1_D, rs2_D, usesRs1_D, usesRs2_D, rd_E, memRead_E, isMul_E, branchTaken_M,
    input  stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mulBusy,
           stallCycles, flushEvents
  );

  modport slave (
    input  rs1_D, rs2_D, usesRs1_D, usesRs2_D, rd_E, memRead_E, isMul_E, branchTaken_M,
    output stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, mulBusy,
           stallCycles, flushEvents
  );

endinterface

// File: rtl/hazard_ctrl_perf_counter.sv
// Free-running event counter, wraps at 2^CNT_W, cleared by reset.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for load-use, taken-branch and (with HAZARD_MUL_EN) multi-cycle MUL.
// Define HAZARD_MUL_EN to compile in the MULWAIT state and its wait counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned WAIT_W = 4;

  hz_state_e state_q, state_d;
  logic      load_use;
  logic      stall_f, stall_d, stall_e;
  logic      flush_d, flush_e, flush_m;
  logic      mul_busy;
  logic      flush_evt;

  assign load_use = (state_q == RUN) && hz.memRead_E && (hz.rd_E != XZR) &&
                    (src_match(hz.usesRs1_D, hz.rs1_D, hz.rd_E) ||
                     src_match(hz.usesRs2_D, hz.rs2_D, hz.rd_E));

`ifdef HAZARD_MUL_EN
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  logic unused_is_mul;
  assign unused_is_mul = hz.isMul_E;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Branch beats load-use beats multiply; MULWAIT holds EX and bubbles MEM.
  always_comb begin
    state_d   = state_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    mul_busy  = 1'b0;
    flush_evt = 1'b0;
`ifdef HAZARD_MUL_EN
    wait_d    = wait_q;
`endif
    case (state_q)
      RUN: begin
        if (hz.branchTaken_M) begin
          flush_d   = 1'b1;
          flush_e   = 1'b1;
          flush_m   = 1'b1;
          flush_evt = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
`ifdef HAZARD_MUL_EN
        else if (hz.isMul_E) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_e  = 1'b1;
          flush_m  = 1'b1;
          mul_busy = 1'b1;
          wait_d   = WAIT_W'(MUL_LAT - 2);
          state_d  = MULWAIT;
        end
`endif
      end
`ifdef HAZARD_MUL_EN
      MULWAIT: begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        flush_m  = 1'b1;
        mul_busy = 1'b1;
        if (wait_q == '0) state_d = RUN;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
`endif
      default: state_d = RUN;
    endcase
  end

  assign hz.stall_F = stall_f;
  assign hz.stall_D = stall_d;
  assign hz.stall_E = stall_e;
  assign hz.flush_D = flush_d;
  assign hz.flush_E = flush_e;
  assign hz.flush_M = flush_m;
  assign hz.mulBusy = mul_busy;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_f),
    .count (hz.stallCycles)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_evt),
    .count (hz.flushEvents)
  );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage LEGv8 core. It sequences the execute stage and the pipeline registers around it by generating stall and flush controls for three cases: load-use hazards, taken branches resolved in MEM, and, optionally, multi-cycle multiplies held in EX. It sits beside the datapath, watches decode/execute/memory stage fields, drives the PC and IF/ID, ID/EX and EX/MEM register enables/clears, and keeps two performance counters.

## Interface
- `MUL_LAT`, default 4: cycles a multiply occupies EX; legal range 2..15.
- `CNT_W`, default 32: width of the performance counters.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rs1_D`, `rs2_D`  in  5 each  source register indices of the instruction in ID.
- `usesRs1_D`, `usesRs2_D`  in  1 each  the ID instruction actually reads that source.
- `rd_E`  in  5  destination index of the instruction in EX.
- `memRead_E`  in  1  the EX instruction is a load (LDUR).
- `isMul_E`  in  1  the EX instruction is MUL; ignored unless `HAZARD_MUL_EN` is defined.
- `branchTaken_M`  in  1  branch in MEM is taken (PCSrc).
- `stall_F`, `stall_D`  out  1 each  hold the PC and hold IF/ID.
- `stall_E`  out  1  hold ID/EX.
- `flush_D`, `flush_E`, `flush_M`  out  1 each  synchronously clear IF/ID, ID/EX and EX/MEM (insert a bubble).
- `mulBusy`  out  1  a multiply is occupying EX.
- `stallCycles`  out  CNT_W  count of cycles with `stall_F`=1.
- `flushEvents`  out  CNT_W  count of branch flushes.

## Operation
- FSM states: RUN and MULWAIT. The MULWAIT state exists only with `HAZARD_MUL_EN`. Reset state is RUN.
- Branch flush, highest priority, RUN only:
  - When `branchTaken_M`=1, assert `flush_D`, `flush_E` and `flush_M` in the same cycle, combinationally.
  - Suppress all stalls in that cycle.
  - Increment `flushEvents`.
- Load-use:
  - Hazard condition: RUN && `memRead_E` && `rd_E`≠31 && ((`usesRs1_D` && `rs1_D`==`rd_E`) || (`usesRs2_D` && `rs2_D`==`rd_E`)).
  - Response in the same cycle: `stall_F`=`stall_D`=1 and `flush_E`=1. This gives exactly one bubble; the hazard clears on its own next cycle.
  - Register 31 (XZR) never creates a hazard.
- Multiply, when enabled:
  - In RUN, `isMul_E`=1 with no branch flush: load the counter with MUL_LAT-2, go to MULWAIT.
  - In that RUN cycle and in every MULWAIT cycle: `stall_F`=`stall_D`=`stall_E`=1, `flush_M`=1, `mulBusy`=1.
  - In MULWAIT, the counter decrements each cycle. When it reads 0, return to RUN at the next edge. The result is that EX is occupied for exactly MUL_LAT cycles.
  - A load-use condition arising in MULWAIT is masked; it is re-evaluated in RUN.
  - `branchTaken_M` is ignored in MULWAIT, because MEM holds bubbles then.
- Simultaneous events:
  - A branch in MEM with a multiply in EX: the branch wins, the multiply is flushed, and no MULWAIT is entered.
  - A load-use condition and `isMul_E` cannot both hold, since the EX instruction is a single instruction. If both inputs are asserted, load-use takes precedence.
- Counters: `stallCycles` increments by 1 on every edge where `stall_F`=1. Both counters wrap at 2^CNT_W.

## Timing
- All stall/flush outputs are combinational from the inputs and state (Mealy), valid before the same edge they act on.
- Reset values:
  - State RUN, wait counter 0.
  - `stallCycles`=`flushEvents`=0.
  - With inputs idle, every control output is 0.
- Reset asserted mid-MULWAIT: the FSM returns to RUN immediately (asynchronously) and `mulBusy` falls without waiting for an edge. Counters clear.
- Latency: a load-use costs 1 cycle; a multiply costs MUL_LAT-1 extra cycles; a taken branch costs 3 cycles of squashed instructions.

## Configuration
- `HAZARD_MUL_EN` defined: the MULWAIT state, the wait counter and `isMul_E` handling are compiled in.
- `HAZARD_MUL_EN` undefined: the FSM is RUN only. `isMul_E` is unused, and `mulBusy` and `stall_E` are tied to 0.
- The ports are identical in both builds.

## Structure
- `hazard_pkg`: the state enum (RUN, MULWAIT), the constant XZR=5'd31, and the register-index width 5.
- Sub-module `perf_counter` (CNT_W parameter, `clk`, `reset`, `inc`, `count`), instantiated twice, once for `stallCycles` and once for `flushEvents`.

## Test plan
- Load-use hit: `memRead_E`=1, `rd_E`=3, `rs1_D`=3, `usesRs1_D`=1 -> `stall_F`=`stall_D`=`flush_E`=1 for one cycle; `stallCycles` 0->1.
- XZR and non-use: `rd_E`=31 with `rs2_D`=31, or `rd_E`=5 with `usesRs1_D`=0 and `rs1_D`=5 -> all outputs stay 0.
- Branch flush: `branchTaken_M`=1 together with a load-use condition -> `flush_D`=`flush_E`=`flush_M`=1, `stall_F`=0; `flushEvents`=1.
- Multiply, `HAZARD_MUL_EN`, MUL_LAT=4: `isMul_E` pulsed -> `mulBusy`=`stall_E`=`flush_M`=1 for exactly 4 cycles, then RUN; `stallCycles`=4.
- Multiply against a branch: `isMul_E`=1 and `branchTaken_M`=1 in the same cycle -> flushes only; `mulBusy`=0 on the next cycle.
- Reset mid-multiply: assert `reset` in the 2nd MULWAIT cycle -> `mulBusy`=0 and both counters 0 immediately, with no clock edge needed.
